// File: rtl/mem_access_stage_if.sv
// EX/M inputs, data-memory bus and M/W outputs of the memory stage.
// The slave side is the stage itself; the master side is whatever drives it.
interface mem_access_stage_if;
   // EX/M pipeline register
   logic [2:0]  strCtrlM;
   logic        RegWriteM;
   logic        MemWriteM;
   logic        MemtoRegM;
   logic [31:0] ALUoutM;
   logic [31:0] r2M;
   logic [4:0]  rdM;
   // data memory
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   // pipeline control
   logic        stallM;
   logic        excM;
   logic        berrM;
   // M/W pipeline register
   logic        RegWriteW;
   logic        MemtoRegW;
   logic [31:0] ALUoutW;
   logic [31:0] ReadDataW;
   logic [4:0]  rdW;

   modport slave (
      input  strCtrlM, RegWriteM, MemWriteM, MemtoRegM, ALUoutM, r2M, rdM,
      input  dmem_rdata, dmem_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output stallM, excM, berrM,
      output RegWriteW, MemtoRegW, ALUoutW, ReadDataW, rdW
   );

   modport master (
      output strCtrlM, RegWriteM, MemWriteM, MemtoRegM, ALUoutM, r2M, rdM,
      output dmem_rdata, dmem_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  stallM, excM, berrM,
      input  RegWriteW, MemtoRegW, ALUoutW, ReadDataW, rdW
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32 memory stage: aligned data-memory access with a ready handshake,
// timeout abort, load extension and the M/W pipeline register.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_access_stage_if.slave  bus
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   typedef struct packed {
      logic        regwrite;
      logic        memtoreg;
      logic [31:0] aluout;
      logic [31:0] rdata;
      logic [4:0]  rd;
   } mw_t;

   localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   mw_t         r_mw;

   logic        w_access, w_size_ok, w_mis, w_ok;
   logic        w_req, w_stall, w_exc, w_berr, w_done;
   logic [31:0] w_wdata, w_shift, w_ldext;
   logic [3:0]  w_strb;
   logic [1:0]  w_lane;

   assign w_access = bus.MemWriteM | bus.MemtoRegM;
   assign w_lane   = bus.ALUoutM[1:0];

   // Size legality and alignment; BU/HU only exist for loads.
   always_comb begin
      w_size_ok = 1'b0;
      w_mis     = 1'b0;
      case (bus.strCtrlM)
         3'b000: w_size_ok = 1'b1;
         3'b001: begin w_size_ok = 1'b1; w_mis = w_lane[0]; end
         3'b010: begin w_size_ok = 1'b1; w_mis = (w_lane != 2'b00); end
         3'b100: w_size_ok = ~bus.MemWriteM;
         3'b101: begin w_size_ok = ~bus.MemWriteM; w_mis = w_lane[0]; end
         default: w_size_ok = 1'b0;
      endcase
   end

   assign w_ok = w_access & w_size_ok & ~w_mis;

   // Store data replicated on every lane; strobes select the live bytes.
   always_comb begin
      w_wdata = bus.r2M;
      w_strb  = 4'b1111;
      case (bus.strCtrlM[1:0])
         2'b00: begin
            w_wdata = {4{bus.r2M[7:0]}};
            w_strb  = 4'b0001 << w_lane;
         end
         2'b01: begin
            w_wdata = {2{bus.r2M[15:0]}};
            w_strb  = w_lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_wdata = bus.r2M;
            w_strb  = 4'b1111;
         end
      endcase
   end

   // Shift the addressed lane down, then sign- or zero-extend it.
   assign w_shift = bus.dmem_rdata >> {w_lane, 3'b000};

   always_comb begin
      w_ldext = bus.dmem_rdata;
      case (bus.strCtrlM)
         3'b000:  w_ldext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ldext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ldext = {24'h0, w_shift[7:0]};
         3'b101:  w_ldext = {16'h0, w_shift[15:0]};
         default: w_ldext = bus.dmem_rdata;
      endcase
   end

   // FSM state and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state plus request/stall/exception outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req       = 1'b0;
      w_stall     = 1'b0;
      w_exc       = 1'b0;
      w_berr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               if (w_ok) begin
                  w_req = 1'b1;
                  if (!bus.dmem_ready) begin
                     w_stall     = 1'b1;
                     w_state_nxt = S_WAIT;
                     w_cnt_nxt   = 8'd1;
                  end
               end else begin
                  w_exc = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (bus.dmem_ready) begin
               w_req       = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 8'd0;
            end else if (r_cnt >= TIMEOUT) begin
               // Give up: drop the request and let the pipeline move on.
               w_berr      = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_req     = 1'b1;
               w_stall   = 1'b1;
               w_cnt_nxt = 8'(r_cnt + 8'd1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   // Combinational outputs are forced low the moment reset asserts.
   assign w_done         = w_req & bus.dmem_ready & ~rst;
   assign bus.dmem_req   = w_req & ~rst;
   assign bus.dmem_we    = w_req & ~rst & bus.MemWriteM;
   assign bus.dmem_addr  = {bus.ALUoutM[31:2], 2'b00};
   assign bus.dmem_wdata = w_wdata;
   assign bus.dmem_wstrb = bus.dmem_we ? w_strb : 4'b0000;
   assign bus.stallM     = w_stall & ~rst;
   assign bus.excM       = w_exc & ~rst;
   assign bus.berrM      = w_berr & ~rst;

   // M/W register: bubble on stall, exception or abort; load data only on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mw <= '0;
      end else if (w_stall || w_exc || w_berr) begin
         r_mw.regwrite <= 1'b0;
         r_mw.memtoreg <= 1'b0;
      end else begin
         r_mw.regwrite <= bus.RegWriteM;
         r_mw.memtoreg <= bus.MemtoRegM;
         r_mw.aluout   <= bus.ALUoutM;
         r_mw.rd       <= bus.rdM;
         if (w_done && bus.MemtoRegM) r_mw.rdata <= w_ldext;
      end
   end

   assign bus.RegWriteW = r_mw.regwrite;
   assign bus.MemtoRegW = r_mw.memtoreg;
   assign bus.ALUoutW   = r_mw.aluout;
   assign bus.ReadDataW = r_mw.rdata;
   assign bus.rdW       = r_mw.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table vectors for single-cycle accesses, plus hand sequences
// for wait states, timeout abort and reset during a pending access.
module tb_mem_access_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic        mw, m2r, rw, rdy;
      logic [31:0] alu, r2, rdata;
      logic [4:0]  rd;
      logic        e_req, e_we, e_exc;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, e_addr;
      logic        e_rw, e_m2r, chk_rd;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(
      input logic [2:0] f3, input logic mw, m2r, rw,
      input logic [31:0] alu, r2, rdata, input logic rdy, input logic [4:0] rd,
      input logic e_req, e_we, e_exc, input logic [3:0] e_strb,
      input logic [31:0] e_wdata, e_addr,
      input logic e_rw, e_m2r, chk_rd, input logic [31:0] e_rd);
      vec_t v;
      v.f3 = f3; v.mw = mw; v.m2r = m2r; v.rw = rw; v.alu = alu; v.r2 = r2;
      v.rdata = rdata; v.rdy = rdy; v.rd = rd;
      v.e_req = e_req; v.e_we = e_we; v.e_exc = e_exc; v.e_strb = e_strb;
      v.e_wdata = e_wdata; v.e_addr = e_addr;
      v.e_rw = e_rw; v.e_m2r = e_m2r; v.chk_rd = chk_rd; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic mw, m2r, rw,
                        input logic [31:0] alu, r2, rdata, input logic rdy, input logic [4:0] rd);
      bus.strCtrlM   = f3;
      bus.MemWriteM  = mw;
      bus.MemtoRegM  = m2r;
      bus.RegWriteM  = rw;
      bus.ALUoutM    = alu;
      bus.r2M        = r2;
      bus.dmem_rdata = rdata;
      bus.dmem_ready = rdy;
      bus.rdM        = rd;
   endtask

   initial begin
      int stalls;
      int hit;

      //               f3     mw m2r rw alu           r2            rdata         rdy rd  | req we exc strb    wdata         addr          rwW m2rW chk rd
      vecs[0]  = mk(3'b010, 0, 1, 1, 32'h100, 32'h0,        32'hDEADBEEF, 1, 5,  1, 0, 0, 4'h0, 32'h0,        32'h100, 1, 1, 1, 32'hDEADBEEF);
      vecs[1]  = mk(3'b001, 1, 0, 0, 32'h202, 32'h1234ABCD, 32'h0,        1, 0,  1, 1, 0, 4'hC, 32'hABCDABCD, 32'h200, 0, 0, 0, 32'h0);
      vecs[2]  = mk(3'b000, 1, 0, 0, 32'h301, 32'h000000A5, 32'h0,        1, 0,  1, 1, 0, 4'h2, 32'hA5A5A5A5, 32'h300, 0, 0, 0, 32'h0);
      vecs[3]  = mk(3'b010, 1, 0, 0, 32'h400, 32'hCAFEF00D, 32'h0,        1, 0,  1, 1, 0, 4'hF, 32'hCAFEF00D, 32'h400, 0, 0, 0, 32'h0);
      vecs[4]  = mk(3'b001, 0, 1, 1, 32'h102, 32'h0,        32'h80011234, 1, 6,  1, 0, 0, 4'h0, 32'h0,        32'h100, 1, 1, 1, 32'hFFFF8001);
      vecs[5]  = mk(3'b101, 0, 1, 1, 32'h102, 32'h0,        32'h80011234, 1, 6,  1, 0, 0, 4'h0, 32'h0,        32'h100, 1, 1, 1, 32'h00008001);
      vecs[6]  = mk(3'b000, 0, 1, 1, 32'h101, 32'h0,        32'h00007F00, 1, 9,  1, 0, 0, 4'h0, 32'h0,        32'h100, 1, 1, 1, 32'h0000007F);
      vecs[7]  = mk(3'b100, 0, 1, 1, 32'h102, 32'h0,        32'h00AB0000, 1, 9,  1, 0, 0, 4'h0, 32'h0,        32'h100, 1, 1, 1, 32'h000000AB);
      vecs[8]  = mk(3'b010, 0, 1, 1, 32'h101, 32'h0,        32'h0,        0, 3,  0, 0, 1, 4'h0, 32'h0,        32'h0,   0, 0, 0, 32'h0);
      vecs[9]  = mk(3'b001, 0, 1, 1, 32'h103, 32'h0,        32'h0,        0, 3,  0, 0, 1, 4'h0, 32'h0,        32'h0,   0, 0, 0, 32'h0);
      vecs[10] = mk(3'b011, 0, 1, 1, 32'h100, 32'h0,        32'h0,        0, 3,  0, 0, 1, 4'h0, 32'h0,        32'h0,   0, 0, 0, 32'h0);
      vecs[11] = mk(3'b100, 1, 0, 0, 32'h100, 32'h5,        32'h0,        0, 0,  0, 0, 1, 4'h0, 32'h0,        32'h0,   0, 0, 0, 32'h0);
      vecs[12] = mk(3'b001, 1, 0, 0, 32'h201, 32'h5,        32'h0,        0, 0,  0, 0, 1, 4'h0, 32'h0,        32'h0,   0, 0, 0, 32'h0);
      vecs[13] = mk(3'b000, 0, 0, 1, 32'h12345678, 32'h0,   32'h0,        1, 7,  0, 0, 0, 4'h0, 32'h0,        32'h0,   1, 0, 0, 32'h0);

      drive(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",       32'(bus.dmem_req),  32'd0);
      chk("rst_stall",     32'(bus.stallM),    32'd0);
      chk("rst_exc",       32'(bus.excM),      32'd0);
      chk("rst_berr",      32'(bus.berrM),     32'd0);
      chk("rst_regwriteW", 32'(bus.RegWriteW), 32'd0);
      chk("rst_memtoregW", 32'(bus.MemtoRegW), 32'd0);
      chk("rst_aluoutW",   bus.ALUoutW,        32'd0);
      chk("rst_readdataW", bus.ReadDataW,      32'd0);
      chk("rst_rdW",       32'(bus.rdW),       32'd0);
      rst = 1'b0;

      // Single-cycle vectors: zero-wait accesses, exceptions, plain ALU op.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].f3, vecs[i].mw, vecs[i].m2r, vecs[i].rw, vecs[i].alu,
               vecs[i].r2, vecs[i].rdata, vecs[i].rdy, vecs[i].rd);
         @(negedge clk);
         chk($sformatf("v%0d_req", i),   32'(bus.dmem_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d_exc", i),   32'(bus.excM),     32'(vecs[i].e_exc));
         chk($sformatf("v%0d_stall", i), 32'(bus.stallM),   32'd0);
         chk($sformatf("v%0d_berr", i),  32'(bus.berrM),    32'd0);
         if (vecs[i].e_req) begin
            chk($sformatf("v%0d_addr", i), bus.dmem_addr,       vecs[i].e_addr);
            chk($sformatf("v%0d_we", i),   32'(bus.dmem_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d_strb", i), 32'(bus.dmem_wstrb), 32'(vecs[i].e_strb));
            if (vecs[i].e_we)
               chk($sformatf("v%0d_wdata", i), bus.dmem_wdata, vecs[i].e_wdata);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_regwriteW", i), 32'(bus.RegWriteW), 32'(vecs[i].e_rw));
         chk($sformatf("v%0d_memtoregW", i), 32'(bus.MemtoRegW), 32'(vecs[i].e_m2r));
         if (vecs[i].e_rw) begin
            chk($sformatf("v%0d_rdW", i),     32'(bus.rdW), 32'(vecs[i].rd));
            chk($sformatf("v%0d_aluoutW", i), bus.ALUoutW,  vecs[i].alu);
         end
         if (vecs[i].chk_rd)
            chk($sformatf("v%0d_readdataW", i), bus.ReadDataW, vecs[i].e_rd);
      end

      // LB / LBU at 0x103 with ready arriving after three stalled cycles.
      for (int pass = 0; pass < 2; pass++) begin
         drive(pass == 0 ? 3'b000 : 3'b100, 0, 1, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 5'd10);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("lb%0d_stall%0d", pass, k), 32'(bus.stallM),   32'd1);
            chk($sformatf("lb%0d_req%0d", pass, k),   32'(bus.dmem_req), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("lb%0d_bubble%0d", pass, k), 32'(bus.RegWriteW), 32'd0);
         end
         bus.dmem_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("lb%0d_stall_done", pass), 32'(bus.stallM), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("lb%0d_readdataW", pass), bus.ReadDataW,
             pass == 0 ? 32'hFFFFFF80 : 32'h00000080);
         chk($sformatf("lb%0d_regwriteW", pass), 32'(bus.RegWriteW), 32'd1);
         chk($sformatf("lb%0d_memtoregW", pass), 32'(bus.MemtoRegW), 32'd1);
      end

      // LW with ready never asserted: abort after the timeout.
      drive(3'b010, 0, 1, 1, 32'h500, 32'h0, 32'h0, 0, 5'd11);
      stalls = 0;
      hit    = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.berrM) begin
            hit = c;
            chk("to_stall_at_abort", 32'(bus.stallM),   32'd0);
            chk("to_req_at_abort",   32'(bus.dmem_req), 32'd0);
            break;
         end
         if (bus.stallM) stalls++;
         @(posedge clk);
         #1;
      end
      chk("to_abort_cycle", 32'(hit),    32'd16);
      chk("to_stall_count", 32'(stalls), 32'd16);
      @(posedge clk);
      #1;
      chk("to_bubble",     32'(bus.RegWriteW), 32'd0);
      chk("to_berr_pulse", 32'(bus.berrM),     32'd0);
      bus.dmem_ready = 1'b1;
      bus.dmem_rdata = 32'h0BADF00D;
      @(negedge clk);
      chk("to_idle_nostall", 32'(bus.stallM), 32'd0);
      @(posedge clk);
      #1;
      chk("to_after_readdataW", bus.ReadDataW, 32'h0BADF00D);

      // Reset while waiting, then a normal LW.
      drive(3'b010, 0, 1, 1, 32'h600, 32'h0, 32'h0, 0, 5'd12);
      repeat (2) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("rstw_req",       32'(bus.dmem_req),  32'd0);
      chk("rstw_stall",     32'(bus.stallM),    32'd0);
      chk("rstw_regwriteW", 32'(bus.RegWriteW), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.dmem_ready = 1'b1;
      bus.dmem_rdata = 32'h11223344;
      @(negedge clk);
      chk("rstw_lw_stall", 32'(bus.stallM),   32'd0);
      chk("rstw_lw_req",   32'(bus.dmem_req), 32'd1);
      @(posedge clk);
      #1;
      chk("rstw_lw_readdataW", bus.ReadDataW,        32'h11223344);
      chk("rstw_lw_regwriteW", 32'(bus.RegWriteW),   32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
